// File: rtl/servo_pkg.sv
// Shared register offsets, the target clamp, and the parameter sanity check
// for the APB servo PWM array.
package servo_pkg;

    localparam logic [7:0] OFF_CTRL        = 8'h00;
    localparam logic [7:0] OFF_STEP        = 8'h04;
    localparam logic [7:0] OFF_STATUS      = 8'h08;
    localparam logic [7:0] OFF_TARGET_BASE = 8'h20;
    localparam logic [7:0] OFF_ACTIVE_BASE = 8'h40;
    localparam int         MAX_CH          = 8;

    function automatic logic [31:0] clamp(
        input logic [31:0] v,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

    // Pulse window must sit strictly inside one period, and the period
    // must be countable in the counter width.
    function automatic bit params_ok(
        input int nch,
        input int cnt_w,
        input int period,
        input int pmin,
        input int pmax,
        input int preset
    );
        return (nch >= 1) && (nch <= MAX_CH) && (cnt_w >= 2) && (cnt_w <= 31) &&
               (pmin <= preset) && (preset <= pmax) && (pmax < period) &&
               (period <= (1 << cnt_w));
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: active width register stepped toward the target at each
// period wrap, and the registered pulse compare against the shared counter.
module servo_slew_channel #(
    parameter int CNT_W       = 21,
    parameter int PULSE_RESET = 150000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_wrap,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_step,
    input  logic [CNT_W-1:0] i_target,
    output logic [CNT_W-1:0] o_active,
    output logic             o_pwm
);

    logic [CNT_W-1:0] r_active;
    logic             r_pwm;

    logic [CNT_W:0]   w_tgt_x;
    logic [CNT_W:0]   w_act_x;
    logic [CNT_W:0]   w_step_x;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W:0]   w_delta;
    logic [CNT_W-1:0] w_next;
    logic             w_up;

    // One extra bit so the distance and the step can never wrap.
    assign w_tgt_x  = {1'b0, i_target};
    assign w_act_x  = {1'b0, r_active};
    assign w_step_x = {1'b0, i_step};
    assign w_up     = w_tgt_x > w_act_x;
    assign w_diff   = w_up ? (w_tgt_x - w_act_x) : (w_act_x - w_tgt_x);
    assign w_delta  = ((i_step == '0) || (w_step_x >= w_diff)) ? w_diff : w_step_x;
    assign w_next   = CNT_W'(w_up ? (w_act_x + w_delta) : (w_act_x - w_delta));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_active <= CNT_W'(PULSE_RESET);
            r_pwm    <= 1'b0;
        end else begin
            if (i_wrap) begin
                r_active <= w_next;
            end
            r_pwm <= i_en && (i_cnt < r_active);
        end
    end

    assign o_active = r_active;
    assign o_pwm    = r_pwm;

endmodule

// File: rtl/apb_servo_array.sv
// APB3 slave driving NUM_CH servo PWM outputs from one shared period counter,
// with clamped targets, wrap-synchronous updates and optional slew limiting.
module apb_servo_array
    import servo_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 21,
    parameter int PWM_PERIOD  = 2000000,
    parameter int PULSE_MIN   = 100000,
    parameter int PULSE_MAX   = 200000,
    parameter int PULSE_RESET = 150000
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] servo_pwm
);

    if (!params_ok(NUM_CH, CNT_W, PWM_PERIOD, PULSE_MIN, PULSE_MAX, PULSE_RESET)) begin : g_bad_params
        $fatal(1, "apb_servo_array: need 1<=NUM_CH<=8 and PULSE_MIN<=PULSE_RESET<=PULSE_MAX<PWM_PERIOD");
    end

    logic [7:0]       w_off;
    logic [2:0]       w_idx;
    logic             w_aligned;
    logic             w_idx_ok;
    logic             w_is_ctrl;
    logic             w_is_step;
    logic             w_is_status;
    logic             w_is_target;
    logic             w_is_active;
    logic             w_err;
    logic             w_wr;
    logic             w_wrap;
    logic             w_unused_addr;
    logic [CNT_W-1:0] w_clamped;
    logic [31:0]      w_rdata;
    logic [NUM_CH-1:0] w_status;
    logic [CNT_W-1:0] w_target [NUM_CH];
    logic [CNT_W-1:0] w_active [NUM_CH];

    logic             r_en;
    logic [CNT_W-1:0] r_step;
    logic [CNT_W-1:0] r_cnt;

    assign w_off         = PADDR[7:0];
    assign w_idx         = w_off[4:2];
    assign w_unused_addr = ^PADDR[31:8];
    assign w_aligned     = (w_off[1:0] == 2'b00);
    assign w_idx_ok      = ({1'b0, w_idx} < 4'(NUM_CH));
    assign w_is_ctrl     = (w_off == OFF_CTRL);
    assign w_is_step     = (w_off == OFF_STEP);
    assign w_is_status   = (w_off == OFF_STATUS);
    assign w_is_target   = w_aligned && w_idx_ok && (w_off[7:5] == OFF_TARGET_BASE[7:5]);
    assign w_is_active   = w_aligned && w_idx_ok && (w_off[7:5] == OFF_ACTIVE_BASE[7:5]);

    // STATUS and ACTIVE are read-only, so they are errors only for writes.
    assign w_err   = PWRITE ? !(w_is_ctrl || w_is_step || w_is_target)
                            : !(w_is_ctrl || w_is_step || w_is_status || w_is_target || w_is_active);
    assign w_wr    = PSEL && PENABLE && PWRITE && !w_err;
    assign PSLVERR = PSEL && PENABLE && w_err;
    assign PREADY  = 1'b1;

    assign w_clamped = CNT_W'(clamp(PWDATA, 32'(PULSE_MIN), 32'(PULSE_MAX)));

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_en   <= 1'b0;
            r_step <= '0;
        end else begin
            if (w_wr && w_is_ctrl) begin
                r_en <= PWDATA[0];
            end
            if (w_wr && w_is_step) begin
                r_step <= PWDATA[CNT_W-1:0];
            end
        end
    end

    assign w_wrap = r_en && (r_cnt == CNT_W'(PWM_PERIOD - 1));

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_cnt <= '0;
        end else if (!r_en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_target;

        always_ff @(posedge PCLK) begin
            if (!PRESERN) begin
                r_target <= CNT_W'(PULSE_RESET);
            end else if (w_wr && w_is_target && (w_idx == 3'(gi))) begin
                r_target <= w_clamped;
            end
        end

        servo_slew_channel #(
            .CNT_W       (CNT_W),
            .PULSE_RESET (PULSE_RESET)
        ) u_ch (
            .i_clk    (PCLK),
            .i_rst_n  (PRESERN),
            .i_en     (r_en),
            .i_wrap   (w_wrap),
            .i_cnt    (r_cnt),
            .i_step   (r_step),
            .i_target (r_target),
            .o_active (w_active[gi]),
            .o_pwm    (servo_pwm[gi])
        );

        assign w_target[gi] = r_target;
        assign w_status[gi] = (w_active[gi] != r_target);
    end

    always_comb begin
        w_rdata = '0;
        if (PSEL && !w_err) begin
            if (w_is_ctrl) begin
                w_rdata[0] = r_en;
            end else if (w_is_step) begin
                w_rdata[CNT_W-1:0] = r_step;
            end else if (w_is_status) begin
                w_rdata[NUM_CH-1:0] = w_status;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_idx == 3'(i)) begin
                        w_rdata[CNT_W-1:0] = w_is_target ? w_target[i] : w_active[i];
                    end
                end
            end
        end
    end

    assign PRDATA = w_rdata;

endmodule

// File: tb/tb_apb_servo_array.sv
// Directed and randomized bench for apb_servo_array; pulse widths are measured
// per period and compared with a period-level model of targets and slew.
module tb_apb_servo_array;

    localparam int P    = 1000;
    localparam int NCH  = 2;
    localparam int PMIN = 100;
    localparam int PMAX = 200;
    localparam int PRST = 150;

    logic clk, rst_n, psel_a, psel_b, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata_a, prdata_b;
    logic pready_a, pready_b, pslverr_a, pslverr_b;
    logic [NCH-1:0] pwm_a;
    logic [1:0] pwm_b;

    apb_servo_array #(.NUM_CH(NCH), .CNT_W(21), .PWM_PERIOD(P),
                      .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .PULSE_RESET(PRST)) dut (
        .PCLK(clk), .PRESERN(rst_n), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a),
        .PSLVERR(pslverr_a), .servo_pwm(pwm_a));

    apb_servo_array dut_def (
        .PCLK(clk), .PRESERN(rst_n), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b),
        .PSLVERR(pslverr_b), .servo_pwm(pwm_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;

    // Measurement state (sampled on negedges)
    int hi_cnt [NCH];
    int last_w [NCH];
    bit prev0, got_rise;

    // Period-level reference model
    int m_tgt [NCH];
    int m_act [NCH];
    int m_cur [NCH];
    int m_step;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (pwm_a[0] && !prev0) begin
            for (int i = 0; i < NCH; i++) begin
                last_w[i] = hi_cnt[i];
                hi_cnt[i] = 0;
            end
            got_rise = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            if (pwm_a[i]) hi_cnt[i]++;
        end
        prev0 = pwm_a[0];
    endtask

    task automatic apb_access(input bit b, input bit wr, input logic [7:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic err);
        paddr = {24'h0, a};
        pwdata = d;
        pwrite = wr;
        if (b) psel_b = 1'b1; else psel_a = 1'b1;
        penable = 1'b0;
        tick();
        penable = 1'b1;
        #1;
        rd  = b ? prdata_b : prdata_a;
        err = b ? pslverr_b : pslverr_a;
        tick();
        psel_a = 1'b0;
        psel_b = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
    endtask

    task automatic wr_ok(input string tag, input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic err;
        apb_access(1'b0, 1'b1, a, d, rd, err);
        check({tag, "_slverr"}, 32'(err), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic err;
        apb_access(1'b0, 1'b0, a, 32'd0, rd, err);
        check(tag, rd, exp);
    endtask

    function automatic int clampv(input int v);
        return (v < PMIN) ? PMIN : ((v > PMAX) ? PMAX : v);
    endfunction

    function automatic int status_exp();
        int s = 0;
        for (int i = 0; i < NCH; i++) if (m_act[i] != m_tgt[i]) s |= (1 << i);
        return s;
    endfunction

    // Each wrap moves active toward target by at most STEP (0 = jump).
    task automatic model_wrap();
        for (int i = 0; i < NCH; i++) begin
            int d = m_tgt[i] - m_act[i];
            if (m_step == 0 || (d <= m_step && -d <= m_step)) m_act[i] = m_tgt[i];
            else if (d > 0) m_act[i] += m_step;
            else m_act[i] -= m_step;
        end
    endtask

    task automatic wait_rise(output bit ok);
        got_rise = 1'b0;
        for (int k = 0; k < 2 * P + 10 && !got_rise; k++) tick();
        ok = got_rise;
    endtask

    task automatic first_period(input string tag);
        bit ok;
        wait_rise(ok);
        check({tag, "_rise"}, 32'(ok), 32'd1);
        for (int i = 0; i < NCH; i++) m_cur[i] = m_act[i];
    endtask

    task automatic period_check(input string tag);
        bit ok;
        wait_rise(ok);
        check({tag, "_rise"}, 32'(ok), 32'd1);
        for (int i = 0; i < NCH; i++)
            check($sformatf("%s_width%0d", tag, i), 32'(last_w[i]), 32'(m_cur[i]));
        model_wrap();
        for (int i = 0; i < NCH; i++) m_cur[i] = m_act[i];
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_tgt[i] = PRST;
            m_act[i] = PRST;
        end
        m_step = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        int lo_seen;

        rst_n = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; prev0 = 1'b0; got_rise = 1'b0;
        for (int i = 0; i < NCH; i++) begin hi_cnt[i] = 0; last_w[i] = 0; end
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        paddr = 32'h20;
        tick();

        // Reset state
        check("rst_prdata_idle", prdata_a, 32'd0);
        check("rst_pslverr", 32'(pslverr_a), 32'd0);
        check("rst_pready", 32'(pready_a), 32'd1);
        check("rst_pwm", 32'(pwm_a), 32'd0);
        check("rst_pwm_def", 32'(pwm_b), 32'd0);
        rd_chk("rst_ctrl", 8'h00, 32'd0);
        rd_chk("rst_step", 8'h04, 32'd0);
        rd_chk("rst_status", 8'h08, 32'd0);
        for (int i = 0; i < NCH; i++) begin
            rd_chk($sformatf("rst_target%0d", i), 8'(8'h20 + 4 * i), 32'(PRST));
            rd_chk($sformatf("rst_active%0d", i), 8'(8'h40 + 4 * i), 32'(PRST));
        end

        // Clamp on the default-parameter instance
        apb_access(1'b1, 1'b1, 8'h20, 32'd5, rd, err);
        check("def_wr0_slverr", 32'(err), 32'd0);
        apb_access(1'b1, 1'b1, 8'h24, 32'd999999, rd, err);
        check("def_wr1_slverr", 32'(err), 32'd0);
        apb_access(1'b1, 1'b0, 8'h20, 32'd0, rd, err);
        check("def_target0_clamp", rd, 32'd100000);
        apb_access(1'b1, 1'b0, 8'h24, 32'd0, rd, err);
        check("def_target1_clamp", rd, 32'd200000);

        // Enable: 150-cycle pulses, then slew 150 -> 195 at STEP 10
        wr_ok("en_on", 8'h00, 32'd1);
        first_period("p0");
        repeat (20) tick();
        wr_ok("step10", 8'h04, 32'd10);
        m_step = 10;
        wr_ok("tgt0_195", 8'h20, 32'd195);
        m_tgt[0] = 195;
        for (int k = 1; k <= 6; k++) begin
            period_check($sformatf("slew%0d", k));
            rd_chk($sformatf("slew%0d_status", k), 8'h08, 32'(status_exp()));
            rd_chk($sformatf("slew%0d_active0", k), 8'h40, 32'(m_act[0]));
        end

        // Mid-pulse write must not disturb the pulse in progress
        repeat (50) tick();
        wr_ok("tgt0_mid", 8'h20, 32'd120);
        m_tgt[0] = 120;
        rd_chk("tgt0_mid_rb", 8'h20, 32'd120);
        period_check("midpulse");

        // TARGET write landing exactly on the wrap edge
        repeat (P - 3) tick();
        wr_ok("tgt1_wrap", 8'h24, 32'd110);
        period_check("wrapedge_t");
        m_tgt[1] = 110;
        period_check("wrapedge_t2");

        // STEP write on the wrap edge: old STEP used for that wrap
        repeat (P - 3) tick();
        wr_ok("step_wrap", 8'h04, 32'd0);
        period_check("wrapedge_s");
        m_step = 0;
        period_check("wrapedge_s2");

        // Error accesses leave the register file alone
        apb_access(1'b0, 1'b0, 8'(8'h20 + 4 * NCH), 32'd0, rd, err);
        check("err_rd_tgtN_slverr", 32'(err), 32'd1);
        check("err_rd_tgtN_data", rd, 32'd0);
        apb_access(1'b0, 1'b1, 8'h40, 32'd177, rd, err);
        check("err_wr_active_slverr", 32'(err), 32'd1);
        apb_access(1'b0, 1'b1, 8'h08, 32'd3, rd, err);
        check("err_wr_status_slverr", 32'(err), 32'd1);
        apb_access(1'b0, 1'b1, 8'h30, 32'd177, rd, err);
        check("err_wr_tgt4_slverr", 32'(err), 32'd1);
        apb_access(1'b0, 1'b0, 8'h0C, 32'd0, rd, err);
        check("err_rd_unmapped_slverr", 32'(err), 32'd1);
        rd_chk("err_active0_kept", 8'h40, 32'(m_act[0]));
        rd_chk("err_target0_kept", 8'h20, 32'(m_tgt[0]));
        rd_chk("err_target1_kept", 8'h24, 32'(m_tgt[1]));
        period_check("after_err");

        // Randomized targets/steps at random points inside each period
        for (int p = 0; p < 8; p++) begin
            int ch, v;
            period_check($sformatf("rnd%0d", p));
            rd_chk($sformatf("rnd%0d_status", p), 8'h08, 32'(status_exp()));
            repeat ($urandom_range(1, 700)) tick();
            if ($urandom_range(0, 3) == 0) begin
                v = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40));
                wr_ok($sformatf("rnd%0d_step", p), 8'h04, 32'(v));
                m_step = v;
            end else begin
                ch = int'($urandom_range(0, NCH - 1));
                v = int'($urandom_range(50, 260));
                wr_ok($sformatf("rnd%0d_tgt", p), 8'(8'h20 + 4 * ch), 32'(v));
                m_tgt[ch] = clampv(v);
                rd_chk($sformatf("rnd%0d_tgt_rb", p), 8'(8'h20 + 4 * ch), 32'(m_tgt[ch]));
            end
        end
        period_check("rnd_last");

        // EN -> 0 mid-pulse: outputs low, actives frozen
        repeat (30) tick();
        wr_ok("en_off", 8'h00, 32'd0);
        tick();
        check("en_off_pwm", 32'(pwm_a), 32'd0);
        lo_seen = 0;
        repeat (P + 200) begin
            tick();
            if (pwm_a != '0) lo_seen++;
        end
        check("en_off_quiet", 32'(lo_seen), 32'd0);
        rd_chk("en_off_active0", 8'h40, 32'(m_act[0]));
        rd_chk("en_off_active1", 8'h44, 32'(m_act[1]));

        // Re-enable: first period uses the frozen actives
        wr_ok("en_on2", 8'h00, 32'd1);
        first_period("reen0");
        period_check("reen1");

        // Reset mid-pulse
        repeat (30) tick();
        check("pre_rst_pwm", 32'(pwm_a), 32'((1 << NCH) - 1));
        rst_n = 1'b0;
        tick();
        check("rst_mid_pwm", 32'(pwm_a), 32'd0);
        rst_n = 1'b1;
        model_reset();
        rd_chk("rst2_ctrl", 8'h00, 32'd0);
        rd_chk("rst2_step", 8'h04, 32'd0);
        for (int i = 0; i < NCH; i++) begin
            rd_chk($sformatf("rst2_target%0d", i), 8'(8'h20 + 4 * i), 32'(m_tgt[i]));
            rd_chk($sformatf("rst2_active%0d", i), 8'(8'h40 + 4 * i), 32'(m_act[i]));
        end
        tick();
        check("rst2_pwm", 32'(pwm_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/apb_servo_array.md
# apb_servo_array

- APB3 slave that generates NUM_CH independent servo PWM outputs from one shared period counter.
- Parametrised successor to the fixed two-channel x/y servo controller; it sits on a CoreAPB3 slot beside the N64 controller interface.
- New over the previous block: per-channel pulse-width clamping, period-synchronous (glitch-free) updates, optional slew-rate limiting, and a readback/status map.

## Interface
- NUM_CH, 2, number of PWM channels (1..8)
- CNT_W, 21, counter and pulse-width register width
- PWM_PERIOD, 2000000, PCLK cycles per PWM period (20 ms at 100 MHz)
- PULSE_MIN, 100000, lowest accepted pulse width in cycles
- PULSE_MAX, 200000, highest accepted pulse width in cycles; must be < PWM_PERIOD
- PULSE_RESET, 150000, reset value of every target and active width
- PCLK  in  1  fabric clock; one clock domain
- PRESERN  in  1  reset: synchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PADDR  in  32  byte address; only [7:0] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  error response
- servo_pwm  out  NUM_CH  PWM outputs; bit i = channel i

## Operation
- Register map (word offsets):
  - 0x00 CTRL: bit0 EN, reset 0.
  - 0x04 STEP: [CNT_W-1:0], maximum width change per period, reset 0 (0 = no slew limit).
  - 0x08 STATUS: read-only. Bit i = 1 when active[i] != target[i].
  - 0x20+4i TARGET[i]: read/write, CNT_W bits.
  - 0x40+4i ACTIVE[i]: read-only, CNT_W bits.
- Write commits on a rising edge where PSEL & PENABLE & PWRITE.
- A TARGET write is clamped to [PULSE_MIN, PULSE_MAX] before it is stored. Readback returns the clamped value.
- Reads are a combinational mux on PADDR[7:0]. Unused bits read 0. PRDATA = 0 whenever PSEL = 0.
- PSLVERR = 1 during the access phase (PSEL & PENABLE) for an unmapped offset, for channel index >= NUM_CH, or for a write to STATUS or ACTIVE. The register file is then unchanged and PRDATA = 0.
- Period counter cnt runs 0..PWM_PERIOD-1 and wraps to 0 while EN = 1. EN = 0 holds cnt at 0.
- On the wrap edge (cnt == PWM_PERIOD-1), each channel updates its active width:
  - STEP = 0: active ← target.
  - Otherwise active moves toward target by min(STEP, |target − active|). There is no overshoot.
- servo_pwm[i] is registered: it goes high on the edge after cnt becomes 0 and stays high for exactly active[i] cycles per period.
- EN = 0: all outputs low, active values frozen.
- EN 0→1: cnt starts at 0 and the first pulse begins one cycle later with the current active values. No update is applied until the first wrap.

## Timing
- Reset values: PRDATA 0, PSLVERR 0, PREADY 1, servo_pwm all 0, cnt 0, EN 0, STEP 0, every TARGET and ACTIVE = PULSE_RESET.
- Reset mid-period: outputs go low on the reset edge. Everything restarts from the reset values.
- Write latency: a TARGET write is visible on readback the next cycle. It reaches the pin no earlier than the next wrap, so a pulse in progress is never truncated or extended.
- Write on the same edge as the wrap: the update uses the target held before that edge. The new target is applied at the following wrap.
- A STEP write on the wrap edge behaves the same way: the old STEP is used.
- Writes to EN take effect the next cycle. EN → 0 mid-pulse drives outputs low the following cycle.
- Slew arithmetic is done in CNT_W+1 bits and cannot wrap. The pulse compare is unsigned cnt < active.

## Structure
- Package servo_pkg holds:
  - register offset constants (CTRL, STEP, STATUS, TARGET_BASE, ACTIVE_BASE);
  - a clamp function;
  - an elaboration check requiring PULSE_MIN <= PULSE_RESET <= PULSE_MAX < PWM_PERIOD.
- Sub-module servo_slew_channel, instantiated NUM_CH times via generate. Each instance holds:
  - the active register;
  - the slew step logic;
  - the registered compare output.
- The top level holds the APB decode, the register file, and the shared counter and wrap strobe.

## Test plan
- Reset, then EN = 1 with PWM_PERIOD = 1000 (test override), PULSE_RESET = 150 → every channel high for 150 cycles, low for 850, repeating.
- Write TARGET[0] = 5 and TARGET[1] = 999999 → readback 100000 and 200000 (default parameters). PSLVERR stays 0.
- STEP = 10, active 150, target 195, period 1000 → widths 160, 170, 180, 190, 195 on successive periods. STATUS bit0 clears after the fifth wrap.
- Write TARGET[0] mid-pulse, and a separate write on the wrap edge → the current pulse is unaltered. The wrap-edge write is applied one period later.
- Read 0x20+4·NUM_CH and write 0x40 → PSLVERR = 1 for that access, PRDATA = 0, registers unchanged.
- Drop PRESERN for one cycle mid-pulse with EN = 1 → servo_pwm = 0 the next cycle. EN = 0 and all TARGET/ACTIVE = PULSE_RESET on readback.
